// File: rtl/avalon_input_port_pkg.sv
// Shared register map and sizing helpers for the Avalon-MM input port.
// Imported by the debounce cell and the top-level register file.
package avalon_input_port_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  typedef enum logic [1:0] {
    REG_DATA = ADDR_DATA,
    REG_MASK = ADDR_MASK,
    REG_EDGE = ADDR_EDGE,
    REG_RAW  = ADDR_RAW
  } reg_addr_e;

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_input_port_debounce.sv
// One input bit: 2-flop synchronizer, hold counter and stable flop.
// The rise/fall strobes fire on the edge where stable changes.
module debounce_bit
  import avalon_input_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          IDLE_LEVEL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_take;

  assign w_diff = r_sync ^ r_stable;
  assign w_take = w_diff && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta   <= IDLE_LEVEL;
      r_sync   <= IDLE_LEVEL;
      r_stable <= IDLE_LEVEL;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      if (!w_diff || w_take)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (w_take)
        r_stable <= r_sync;
    end
  end

  assign o_sync   = r_sync;
  assign o_stable = r_stable;
  assign o_rise   = w_take &  r_sync;
  assign o_fall   = w_take & ~r_sync;

endmodule

// File: rtl/avalon_input_port.sv
// Avalon-MM input peripheral: debounced levels, edge capture and a
// maskable level interrupt for switches and keys.
module avalon_input_port
  import avalon_input_port_pkg::*;
#(
  parameter int          WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          CAPTURE_FALLING = 1'b0,
  parameter bit          IDLE_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      r_readdata;
  logic [31:0]      w_rdata;
  logic             w_rd;
  logic             w_wr;
  logic             w_unused;
  reg_addr_e        w_addr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_db (
      .i_clk   (clk),
      .i_reset (reset),
      .i_pin   (pins[i]),
      .o_sync  (w_sync[i]),
      .o_stable(w_stable[i]),
      .o_rise  (w_rise[i]),
      .o_fall  (w_fall[i])
    );
  end

  assign w_addr   = reg_addr_e'(address);
  assign w_rd     = chipselect & read;
  assign w_wr     = chipselect & write;
  assign w_hit    = CAPTURE_FALLING ? w_fall : w_rise;
  assign w_unused = ^writedata;

  always_comb begin
    w_clr = '0;
    if (w_wr && w_addr == REG_EDGE)
      w_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_addr)
      REG_DATA: w_rdata = 32'(w_stable);
      REG_MASK: w_rdata = 32'(r_mask);
      REG_EDGE: w_rdata = 32'(r_edge);
      REG_RAW:  w_rdata = 32'(w_sync);
      default:  w_rdata = '0;
    endcase
  end

  // A new edge wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
    end else begin
      if (w_rd)
        r_readdata <= w_rdata;
      if (w_wr && w_addr == REG_MASK)
        r_mask <= writedata[WIDTH-1:0];
      r_edge <= (r_edge & ~w_clr) | w_hit;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_avalon_input_port.sv
// Directed bench: rising-capture port plus a falling-capture,
// idle-high port sharing one bus, clock and reset.
module tb_avalon_input_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pins0;
  logic [3:0]  pins1;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata0;
  logic [31:0] readdata1;
  logic        irq0;
  logic        irq1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_input_port #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4),
    .CAPTURE_FALLING(1'b0), .IDLE_LEVEL(1'b0)
  ) u0 (
    .clk(clk), .reset(reset), .pins(pins0),
    .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata0), .irq(irq0)
  );

  avalon_input_port #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4),
    .CAPTURE_FALLING(1'b1), .IDLE_LEVEL(1'b1)
  ) u1 (
    .clk(clk), .reset(reset), .pins(pins1),
    .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata1), .irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered and left on a falling edge; one registering edge inside.
  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    pins0      = 4'b0000;
    pins1      = 4'b1111;
    address    = 2'd0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    step(3);
    reset = 1'b0;

    // Reset state
    chk("rst_readdata", readdata0, 32'h0);
    chk("rst_irq", {31'b0, irq0}, 32'h0);
    rd(2'd0); chk("rst_data", readdata0, 32'h0);
    chk("rst_data_idle_hi", readdata1, 32'hF);
    rd(2'd1); chk("rst_mask", readdata0, 32'h0);
    rd(2'd2); chk("rst_edge", readdata0, 32'h0);
    chk("rst_edge_fall", readdata1, 32'h0);
    rd(2'd3); chk("rst_raw", readdata0, 32'h0);
    chk("rst_irq2", {31'b0, irq0}, 32'h0);

    // Rising edge on bit 0, latency of RAW and DATA
    pins0 = 4'b0001;
    rd(2'd3); chk("raw_e1", readdata0, 32'h0);
    rd(2'd3); chk("raw_e2", readdata0, 32'h0);
    rd(2'd3); chk("raw_e3", readdata0, 32'h1);
    step(2);
    rd(2'd0); chk("data_e6", readdata0, 32'h0);
    rd(2'd0); chk("data_e7", readdata0, 32'h1);
    rd(2'd2); chk("edge_b0", readdata0, 32'h1);
    chk("irq_unmasked", {31'b0, irq0}, 32'h0);

    // Three-cycle glitch on bit 2
    pins0 = 4'b0101;
    rd(2'd3); chk("glitch_raw1", readdata0, 32'h1);
    rd(2'd3); chk("glitch_raw2", readdata0, 32'h1);
    rd(2'd3); chk("glitch_raw3", readdata0, 32'h5);
    pins0 = 4'b0001;
    step(8);
    rd(2'd0); chk("glitch_data", readdata0, 32'h1);
    rd(2'd2); chk("glitch_edge", readdata0, 32'h1);
    chk("glitch_irq", {31'b0, irq0}, 32'h0);

    // Mask, irq timing and clear
    wr(2'd2, 32'h1);
    rd(2'd2); chk("edge_cleared", readdata0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1); chk("mask_width", readdata0, 32'hF);
    wr(2'd1, 32'h1);
    rd(2'd1); chk("mask_rb", readdata0, 32'h1);
    pins0 = 4'b0000;
    step(8);
    rd(2'd2); chk("fall_ignored", readdata0, 32'h0);
    chk("irq_fall", {31'b0, irq0}, 32'h0);
    pins0 = 4'b0001;
    step(5);
    chk("irq_before", {31'b0, irq0}, 32'h0);
    step(1);
    chk("irq_rise", {31'b0, irq0}, 32'h1);
    wr(2'd2, 32'h1);
    chk("irq_clear", {31'b0, irq0}, 32'h0);
    rd(2'd2); chk("edge_after_clr", readdata0, 32'h0);

    // Clear collides with a new capture on bit 1
    pins0 = 4'b0011;
    step(5);
    wr(2'd2, 32'h2);
    rd(2'd2); chk("set_wins", readdata0, 32'h2);
    chk("irq_unmasked_b1", {31'b0, irq0}, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0); chk("data_ro", readdata0, 32'h3);

    // Falling capture, idle-high port
    pins1 = 4'b0111;
    step(7);
    rd(2'd2); chk("fall_edge", readdata1, 32'h8);
    rd(2'd0); chk("fall_data", readdata1, 32'h7);
    pins1 = 4'b0011;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd(2'd0); chk("rst_mid_data", readdata1, 32'hF);
    rd(2'd2); chk("rst_mid_edge", readdata1, 32'h0);
    step(3);
    rd(2'd0); chk("rst_cnt_e6", readdata1, 32'hF);
    rd(2'd0); chk("rst_cnt_e7", readdata1, 32'h3);
    rd(2'd2); chk("fall_edge2", readdata1, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_input_port.md
# avalon_input_port

Memory-mapped input peripheral that lets the Nios II processor read board switches and keys, the inbound counterpart of the PIO output port driving LEDR. Pins are synchronized, debounced and edge-captured, then exposed through an Avalon-MM slave with a maskable level interrupt. It sits in the DE1_SoC top level, wired to SW or KEY and to the system interconnect.

## Interface
- WIDTH, 10: number of input pins.
- DEBOUNCE_CYCLES, 500000: cycles an input must hold a new level before it is accepted (10 ms at 50 MHz). Legal range is 1 to 2^24.
- CAPTURE_FALLING, 0: edge polarity. 0 captures 0→1 transitions; 1 captures 1→0 transitions, for active-low KEY inputs.
- IDLE_LEVEL, 0: reset value of the synchronizer and debounced bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pins  in  WIDTH  asynchronous board inputs.
- address  in  2  word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe, qualified by chipselect.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA: debounced level, read-only.
  - 1 IRQ_MASK: read/write, low WIDTH bits.
  - 2 EDGE_CAPTURE: read, or write-1-to-clear.
  - 3 RAW: synchronized, undebounced level, read-only.
- Unused upper readdata bits read 0. Writes to DATA and RAW are ignored.
- Synchronizer: a 2-flop chain per bit; its output is sync.
- Debounce, per bit:
  - When sync equals stable, the counter clears.
  - When they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, stable takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- Edge capture: a bit sets on the edge where stable makes the selected transition. It stays set until cleared by a write of 1 to that bit at address 2.
- Simultaneous clear and new edge on the same bit: set wins.
- irq = OR of (EDGE_CAPTURE & IRQ_MASK), combinational from registers.
- Reset values:
  - sync, stable: all bits IDLE_LEVEL.
  - Counters, IRQ_MASK, EDGE_CAPTURE: 0.
  - readdata: 0. irq: 0.
- Reset asserted mid-debounce or mid-read drops all state; no edge is captured on reset release.

## Timing
- Read latency is fixed at 1 cycle: readdata is registered on the edge where chipselect&read is high and is valid the following cycle. It holds its value otherwise. There is no waitrequest.
- Writes take effect on the edge where chipselect&write is high. A read of the same register in the following cycle returns the new value.
- Pin-to-DATA latency: a pin change held steady appears in stable DEBOUNCE_CYCLES+2 edges after it is first sampled. With DEBOUNCE_CYCLES=1, this is 3 edges.
- EDGE_CAPTURE updates on the same edge as stable. irq asserts in that same cycle if the bit is masked in.
- irq deasserts the cycle after a clearing write or a mask write that removes every pending bit.
- RAW lags pins by 2 edges.

## Structure
- Package avalon_input_port_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_RAW=3.
  - A register-address enum typedef.
- Sub-module debounce_bit: one bit of synchronizer, counter and stable flop, parameterized by DEBOUNCE_CYCLES and IDLE_LEVEL. It outputs sync, stable and a one-cycle rise/fall strobe.
- The top level generates WIDTH instances of debounce_bit and contains the register file and the read mux.

## Test plan
Benches use WIDTH=4 and DEBOUNCE_CYCLES=4.
- Reset, then read each address → readdata 0 for all four; irq=0.
- pins 0000→0001, held → RAW=0001 after 2 edges; DATA=0001 and EDGE_CAPTURE=0001 after 6 edges; irq stays 0 because the mask is 0.
- pins[2] pulses high for 3 cycles → RAW shows the pulse; DATA, EDGE_CAPTURE and irq never change.
- Write MASK=0001, then create an edge on pins[0] → irq rises on the edge where DATA updates. Write EDGE=0001 → irq=0 the next cycle and EDGE reads 0000.
- Clearing write to EDGE bit 1 on the exact edge a new rise of bit 1 is captured → EDGE bit 1 reads 1.
- CAPTURE_FALLING=1, IDLE_LEVEL=1, pins start 1111 → no capture out of reset. Driving pins[3] to 0 → EDGE=1000. Asserting reset mid-count → DATA=1111 and the counter is cleared.
